alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (e.g. integer pipe, address/branch unit).
//  Per-port valid/ready request and response handshakes; round-robin or fixed priority grant.

---
 rtl/alu_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: arbitrates two requesters onto one external combinational ALU.
// A three-state FSM (IDLE -> EXEC -> RESP) keeps one op in flight. The op's opcode and
// operands are held in registers that drive the ALU. The ALU result is captured into
// the owning port's response registers.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_zero,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // port that owns the in-flight op
  logic             rr_q, rr_d;         // port that wins a tie (round-robin mode)
  logic [3:0]       opc_q, opc_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_res_q, rsp0_res_d;
  logic [WIDTH-1:0] rsp1_res_q, rsp1_res_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_zero_q, rsp1_zero_d;
  logic             gnt0_s, gnt1_s;
  logic             prio_s;
  logic             owner_rsp_ready_s;

  // Fixed-priority mode pins the tie-winner to port 0; otherwise it follows the pointer.
  assign prio_s            = FIXED_PRIO ? 1'b0 : rr_q;
  assign owner_rsp_ready_s = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state, grant and datapath-capture logic for the issue FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    opc_d        = opc_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_res_d   = rsp0_res_q;
    rsp1_res_d   = rsp1_res_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_zero_d  = rsp1_zero_q;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt0_s = ~prio_s;
          gnt1_s = prio_s;
        end else begin
          gnt0_s = req0_valid;
          gnt1_s = req1_valid;
        end
        if (gnt0_s) begin
          opc_d   = req0_opcode;
          op1_d   = req0_op1;
          op2_d   = req0_op2;
          owner_d = 1'b0;
          state_d = ST_EXEC;
        end else if (gnt1_s) begin
          opc_d   = req1_opcode;
          op1_d   = req1_op1;
          op2_d   = req1_op2;
          owner_d = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The ALU has had a full cycle on the registered operands; sample it now.
        if (owner_q) begin
          rsp1_res_d   = alu_res;
          rsp1_zero_d  = alu_zero;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_res_d   = alu_res;
          rsp0_zero_d  = alu_zero;
          rsp0_valid_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rsp_ready_s) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
          rr_d    = FIXED_PRIO ? rr_q : ~owner_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      opc_q        <= 4'd0;
      op1_q        <= {WIDTH{1'b0}};
      op2_q        <= {WIDTH{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= {WIDTH{1'b0}};
      rsp1_res_q   <= {WIDTH{1'b0}};
      rsp0_zero_q  <= 1'b0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      opc_q        <= opc_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp1_res_q   <= rsp1_res_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_res   = rsp0_res_q;
  assign rsp1_res   = rsp1_res_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp1_zero  = rsp1_zero_q;
  assign alu_opcode = opc_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a round-robin instance (A) and a
// fixed-priority instance (B) share the same request stimulus, each with its own ALU model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_ready, rsp1_ready;

  logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp0_zero, a_rsp1_zero;
  logic [31:0] a_rsp0_res, a_rsp1_res, a_alu_op1, a_alu_op2, a_alu_res;
  logic [3:0]  a_alu_opcode;
  logic        a_alu_zero;

  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_zero, b_rsp1_zero;
  logic [31:0] b_rsp0_res, b_rsp1_res, b_alu_op1, b_alu_op2, b_alu_res;
  logic [3:0]  b_alu_opcode;
  logic        b_alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA, else 0.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = {31'd0, ($signed(a) < $signed(b))};
      4'd6:    alu_f = {31'd0, (a < b)};
      4'd7:    alu_f = a << b[4:0];
      4'd8:    alu_f = a >> b[4:0];
      4'd9:    alu_f = $unsigned($signed(a) >>> b[4:0]);
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign a_alu_res  = alu_f(a_alu_opcode, a_alu_op1, a_alu_op2);
  assign a_alu_zero = (a_alu_res == 32'd0);
  assign b_alu_res  = alu_f(b_alu_opcode, b_alu_op1, b_alu_op2);
  assign b_alu_zero = (b_alu_res == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(a_rsp0_res), .rsp0_zero(a_rsp0_zero),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(a_rsp1_res), .rsp1_zero(a_rsp1_zero),
    .alu_opcode(a_alu_opcode), .alu_op1(a_alu_op1), .alu_op2(a_alu_op2),
    .alu_res(a_alu_res), .alu_zero(a_alu_zero)
  );

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(b_rsp0_res), .rsp0_zero(b_rsp0_zero),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(b_rsp1_res), .rsp1_zero(b_rsp1_zero),
    .alu_opcode(b_alu_opcode), .alu_op1(b_alu_op1), .alu_op2(b_alu_op2),
    .alu_res(b_alu_res), .alu_zero(b_alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = 4'd0; req1_opcode = 4'd0;
    req0_op1 = 32'd0; req0_op2 = 32'd0; req1_op1 = 32'd0; req1_op2 = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_ready0", {31'd0, a_req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, a_req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd0);
    chk("rst_rsp0_res", a_rsp0_res, 32'd0);
    chk("rst_rsp0_zero", {31'd0, a_rsp0_zero}, 32'd0);
    chk("rst_alu_opcode", {28'd0, a_alu_opcode}, 32'd0);
    chk("rst_alu_op1", a_alu_op1, 32'd0);
    chk("rst_alu_op2", a_alu_op2, 32'd0);

    // 1: port0 ADD 5+7, port1 idle
    req0_valid = 1'b1; req0_opcode = 4'd0; req0_op1 = 32'd5; req0_op2 = 32'd7;
    #1;
    chk("t1_ready0", {31'd0, a_req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, a_req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t1_exec_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd0);
    chk("t1_exec_alu_op1", a_alu_op1, 32'd5);
    chk("t1_exec_alu_op2", a_alu_op2, 32'd7);
    tick();
    chk("t1_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd1);
    chk("t1_rsp0_res", a_rsp0_res, 32'd12);
    chk("t1_rsp0_zero", {31'd0, a_rsp0_zero}, 32'd0);
    chk("t1_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd0);
    tick();
    chk("t1_rsp0_taken", {31'd0, a_rsp0_valid}, 32'd0);

    // 2: both valid SUB 9-9; A alternates 0,1,0,1, B always grants port 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'd1; req0_op1 = 32'd9; req0_op2 = 32'd9;
    req1_valid = 1'b1; req1_opcode = 4'd1; req1_op1 = 32'd9; req1_op2 = 32'd9;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_a_ready0", {31'd0, a_req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_a_ready1", {31'd0, a_req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t2_b_ready0", {31'd0, b_req0_ready}, 32'd1);
      chk("t2_b_ready1", {31'd0, b_req1_ready}, 32'd0);
      tick();
      tick();
      if (i % 2 == 0) begin
        chk("t2_a_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd1);
        chk("t2_a_rsp1_idle", {31'd0, a_rsp1_valid}, 32'd0);
        chk("t2_a_rsp0_res", a_rsp0_res, 32'd0);
        chk("t2_a_rsp0_zero", {31'd0, a_rsp0_zero}, 32'd1);
      end else begin
        chk("t2_a_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd1);
        chk("t2_a_rsp0_idle", {31'd0, a_rsp0_valid}, 32'd0);
        chk("t2_a_rsp1_res", a_rsp1_res, 32'd0);
        chk("t2_a_rsp1_zero", {31'd0, a_rsp1_zero}, 32'd1);
      end
      chk("t2_b_rsp0_valid", {31'd0, b_rsp0_valid}, 32'd1);
      chk("t2_b_rsp1_starved", {31'd0, b_rsp1_valid}, 32'd0);
      tick();
    end

    // 3: backpressure on port1 SRA 0x80000000 >>> 4
    req0_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_opcode = 4'd9; req1_op1 = 32'h8000_0000; req1_op2 = 32'd4;
    #1;
    chk("t3_ready1", {31'd0, a_req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'd0; req0_op1 = 32'd1; req0_op2 = 32'd2;
    #1;
    chk("t3_exec_ready0", {31'd0, a_req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd1);
      chk("t3_hold_rsp1_res", a_rsp1_res, 32'hF800_0000);
      chk("t3_hold_ready0", {31'd0, a_req0_ready}, 32'd0);
      chk("t3_hold_ready1", {31'd0, a_req1_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    chk("t3_rsp1_taken", {31'd0, a_rsp1_valid}, 32'd0);
    chk("t3_ready0_after", {31'd0, a_req0_ready}, 32'd1);
    rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t3_rsp0_res", a_rsp0_res, 32'd3);
    chk("t3_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd1);
    tick();

    // 4: illegal opcode 4'hF on port0
    req0_valid = 1'b1; req0_opcode = 4'hF; req0_op1 = 32'd3; req0_op2 = 32'd4;
    #1;
    chk("t4_ready0", {31'd0, a_req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("t4_alu_opcode", {28'd0, a_alu_opcode}, 32'h0000_000F);
    tick();
    chk("t4_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd1);
    chk("t4_rsp0_res", a_rsp0_res, 32'd0);
    chk("t4_rsp0_zero", {31'd0, a_rsp0_zero}, 32'd1);
    tick();
    chk("t4_rsp0_taken", {31'd0, a_rsp0_valid}, 32'd0);

    // 5a: reset during EXEC (pointer currently favours port 1)
    req1_valid = 1'b1; req1_opcode = 4'd0; req1_op1 = 32'd2; req1_op2 = 32'd3;
    #1;
    chk("t5_ready1", {31'd0, a_req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5e_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd0);
    chk("t5e_rsp1_res", a_rsp1_res, 32'd0);
    chk("t5e_alu_opcode", {28'd0, a_alu_opcode}, 32'd0);
    chk("t5e_alu_op1", a_alu_op1, 32'd0);
    chk("t5e_alu_op2", a_alu_op2, 32'd0);
    tick();
    chk("t5e_no_rsp", {31'd0, a_rsp1_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5e_prio_ready0", {31'd0, a_req0_ready}, 32'd1);
    chk("t5e_prio_ready1", {31'd0, a_req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 5b: reset during RESP
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    #1;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t5r_rsp1_valid", {31'd0, a_rsp1_valid}, 32'd1);
    chk("t5r_rsp1_res", a_rsp1_res, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp1_ready = 1'b1;
    chk("t5r_rsp1_valid_rst", {31'd0, a_rsp1_valid}, 32'd0);
    chk("t5r_rsp1_res_rst", a_rsp1_res, 32'd0);
    chk("t5r_rsp1_zero_rst", {31'd0, a_rsp1_zero}, 32'd0);
    req0_valid = 1'b1; req0_opcode = 4'd0; req0_op1 = 32'd2; req0_op2 = 32'd3;
    req1_valid = 1'b1;
    #1;
    chk("t5r_prio_ready0", {31'd0, a_req0_ready}, 32'd1);
    chk("t5r_prio_ready1", {31'd0, a_req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("t5r_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd1);
    chk("t5r_rsp0_res", a_rsp0_res, 32'd5);
    chk("t5r_rsp1_idle", {31'd0, a_rsp1_valid}, 32'd0);
    tick();

    // 6: SLT vs SLTU on 0xFFFFFFFF, 1; ALU inputs stable while idle
    req0_valid = 1'b1; req0_opcode = 4'd5; req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'd1;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t6_slt_res", a_rsp0_res, 32'd1);
    chk("t6_slt_zero", {31'd0, a_rsp0_zero}, 32'd0);
    tick();
    req0_valid = 1'b1; req0_opcode = 4'd6;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t6_sltu_res", a_rsp0_res, 32'd0);
    chk("t6_sltu_zero", {31'd0, a_rsp0_zero}, 32'd1);
    tick();
    req0_opcode = 4'd2; req0_op1 = 32'h1234_5678; req0_op2 = 32'h0F0F_0F0F;
    req1_opcode = 4'd3; req1_op1 = 32'hAAAA_AAAA; req1_op2 = 32'h5555_5555;
    tick();
    tick();
    tick();
    chk("t6_idle_alu_opcode", {28'd0, a_alu_opcode}, 32'd6);
    chk("t6_idle_alu_op1", a_alu_op1, 32'hFFFF_FFFF);
    chk("t6_idle_alu_op2", a_alu_op2, 32'd1);
    chk("t6_idle_rsp0_valid", {31'd0, a_rsp0_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
